ahb3lite_interconnect_slave_arbiter: RTL

Per-slave-port arbiter for the AHB3-Lite interconnect matrix. It decides which master owns the slave's address phase. Selection is by highest programmed priority, with round-robin among equal-priority requesters. Grant is held across bursts and locked sequences. It also tracks the data-phase owner so the matrix can route HRDATA/HREADYOUT/HRESP back to the correct master.

---
 rtl/ahb3lite_pkg.sv | 9 +
 rtl/ahb3lite_interconnect_slave_priority.sv | 17 +
 rtl/ahb3lite_interconnect_slave_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used across the interconnect matrix.
package ahb3lite_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;
endpackage

// File: rtl/ahb3lite_interconnect_slave_priority.sv
// Highest programmed priority among the currently requesting masters (0 when none request).
module ahb3lite_interconnect_slave_priority #(
    parameter int MASTERS       = 3,
    parameter int PRIORITY_BITS = 2
) (
    input  logic [MASTERS-1:0]                    HSEL,
    input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] mst_priority,
    output logic [PRIORITY_BITS-1:0]              maxprio
);
    always_comb begin
        maxprio = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (HSEL[i] && (mst_priority[i] > maxprio))
                maxprio = mst_priority[i];
        end
    end
endmodule

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave-port arbiter: priority + round-robin address-phase grant with burst/lock hold,
// plus data-phase owner tracking for response routing.
module ahb3lite_interconnect_slave_arbiter
    import ahb3lite_pkg::*;
#(
    parameter int MASTERS       = 3,
    parameter int PRIORITY_BITS = $clog2(MASTERS + 1),
    parameter int MASTER_BITS   = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                                  HCLK,
    input  logic                                  HRESET,
    input  logic [MASTERS-1:0]                    mst_HSEL,
    input  logic [MASTERS-1:0][1:0]               mst_HTRANS,
    input  logic [MASTERS-1:0]                    mst_HMASTLOCK,
    input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] mst_priority,
    input  logic                                  slv_HREADY,
    output logic [MASTERS-1:0]                    grant_o,
    output logic [MASTER_BITS-1:0]                addr_owner_o,
    output logic [MASTER_BITS-1:0]                data_owner_o,
    output logic                                  data_valid_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_BURST, ST_LOCKED} arb_state_e;

    arb_state_e               state, state_n;
    logic [MASTER_BITS-1:0]   rr_ptr, rr_n, owner_n;
    logic [MASTERS-1:0]       req, cand, grant_n;
    logic [PRIORITY_BITS-1:0] maxprio;
    logic                     has_owner, own_sel, own_lock, data_valid_n;
    logic [1:0]               own_trans;

    // First candidate strictly after ptr, searching upward with wrap; ptr itself comes last.
    function automatic logic [MASTER_BITS-1:0] rr_pick(input logic [MASTERS-1:0] c,
                                                       input logic [MASTER_BITS-1:0] ptr);
        logic [MASTER_BITS-1:0] pick;
        logic                   found;
        int                     idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MASTERS; k++) begin
            idx = (int'(ptr) + k) % MASTERS;
            if (!found && c[idx]) begin
                pick  = MASTER_BITS'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < MASTERS; i++)
            req[i] = mst_HSEL[i] && (mst_HTRANS[i] == HTRANS_NONSEQ);
    end

    ahb3lite_interconnect_slave_priority #(
        .MASTERS       (MASTERS),
        .PRIORITY_BITS (PRIORITY_BITS)
    ) u_priority (
        .HSEL         (req),
        .mst_priority (mst_priority),
        .maxprio      (maxprio)
    );

    always_comb begin
        for (int i = 0; i < MASTERS; i++)
            cand[i] = req[i] && (mst_priority[i] == maxprio);
    end

    assign has_owner = |grant_o;
    assign own_sel   = mst_HSEL[addr_owner_o];
    assign own_trans = mst_HTRANS[addr_owner_o];
    assign own_lock  = mst_HMASTLOCK[addr_owner_o];

    always_comb begin
        state_n      = state;
        grant_n      = grant_o;
        owner_n      = addr_owner_o;
        rr_n         = rr_ptr;
        data_valid_n = has_owner && ((own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_SEQ));
        if (has_owner && own_sel && own_lock) begin
            state_n = ST_LOCKED;
        end else if (has_owner && own_sel &&
                     ((own_trans == HTRANS_SEQ) || (own_trans == HTRANS_BUSY))) begin
            state_n = ST_BURST;
        end else if (|cand) begin
            // A dropped HSEL mid-burst lands here too and is simply a release.
            owner_n          = rr_pick(cand, rr_ptr);
            grant_n          = '0;
            grant_n[owner_n] = 1'b1;
            rr_n             = owner_n;
            state_n          = ST_GRANTED;
        end else begin
            grant_n = '0;
            owner_n = '0;
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= ST_IDLE;
            grant_o      <= '0;
            addr_owner_o <= '0;
            data_owner_o <= '0;
            data_valid_o <= 1'b0;
            rr_ptr       <= MASTER_BITS'(MASTERS - 1);
        end else if (slv_HREADY) begin
            state        <= state_n;
            grant_o      <= grant_n;
            addr_owner_o <= owner_n;
            data_owner_o <= addr_owner_o;
            data_valid_o <= data_valid_n;
            rr_ptr       <= rr_n;
        end
    end
endmodule
